fixed_point_divider: RTL and testbench
======================================

// Module: fixed_point_divider
// PURPOSE
//  Sequential signed fixed-point divider, result = A / B, in the same fixed-point format as the accelerator's multiplier.
//  It is the inverse arithmetic unit for the ODE datapath and uses the same start/finish handshake and result/overflow_flag
//  contract as the multiplier. It is a restoring radix-2 divider that produces one quotient bit per clock, with constant latency.
// PARAMETERS
//  WIDTH      16  operand/result width, two's complement
//  FRAC_BITS  10  fractional bits (default Q5.10; 1.0 = 16'h0400)
// PORTS
//  clk            input   1      rising-edge clock
//  rst            input   1      asynchronous reset, active-low (rst=0 resets)
//  A              input   WIDTH  dividend, signed fixed point
//  B              input   WIDTH  divisor, signed fixed point
//  start          input   1      request; sampled only in IDLE/DONE
//  result         output  WIDTH  quotient, signed fixed point, registered
//  overflow_flag  output  1      quotient saturated (range overflow or B==0)
//  finish         output  1      result valid; held until the next operation is accepted
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, result=0, overflow_flag=0, finish=0, start_prev=0, internal regs=0.
//  Acceptance: in IDLE or DONE, when start=1 and start_prev=0 (start_prev = start registered every cycle).
//   A start held high for several cycles triggers exactly one operation.
//   start is ignored in CALC and FIX. A and B are sampled only on the accept edge and may change afterwards.
//  States:
//   IDLE -> CALC on accept.
//    Latch sA=A[W-1], sB=B[W-1], |A|, |B| (W-bit unsigned; |16'h8000| = 32768) and bz=(B==0).
//    Set dividend = |A| << FRAC_BITS (W+FRAC bits). Clear remainder. cnt = W+FRAC-1. finish<=0.
//   CALC: each cycle, shift the next dividend MSB into the remainder.
//    If remainder >= |B|, subtract it and set the quotient bit to 1; otherwise set it to 0.
//    At cnt==0 -> FIX; otherwise cnt-1. Runs exactly W+FRAC cycles (26 by default), also when B==0.
//   FIX: one cycle, then -> DONE with finish<=1. neg = sA^sB; q = magnitude quotient (W+FRAC bits).
//    B==0: overflow_flag=1; result = 16'h8000 if sA, else 16'h7FFF (0/0 -> 16'h7FFF).
//    !neg and q > 2^(W-1)-1: overflow_flag=1, result=16'h7FFF.
//    neg and q > 2^(W-1): overflow_flag=1, result=16'h8000.
//    Otherwise: overflow_flag=0, result = neg ? -q[W-1:0] : q[W-1:0] (q==2^(W-1) with neg gives 16'h8000, no overflow).
//   DONE: hold result, overflow_flag and finish=1. On accept -> CALC, behaving as from IDLE (finish drops the next cycle).
//  Rounding: truncation toward zero on the magnitude, so -1/3 gives -(0.333 truncated).
//  Latency: the accept edge is edge 0; finish rises at edge W+FRAC+2 (28 by default). result is stable while finish=1.
//  Reset mid-operation aborts immediately to IDLE with outputs cleared. There is no partial result.
//  result and overflow_flag change only in FIX or on reset.
// TESTING
//  1 rst=0 for 2 cycles, then release -> result=0, overflow_flag=0, finish=0. No activity while start=0.
//  2 A=16'h0C00 (3.0), B=16'h0800 (2.0), start held 4 cycles -> exactly one operation.
//    finish at edge 28 with result=16'h0600, ovf=0. finish stays 1 until the next accept.
//  3 Sign and truncation:
//    16'hF400/16'h0800 -> 16'hFA00.
//    16'h0400/16'h0C00 -> 16'h0155.
//    16'hFC00/16'h0C00 -> 16'hFEAB.
//    16'h8000/16'h0400 -> 16'h8000, ovf=0.
//  4 Overflow and divide-by-zero:
//    16'h7FFF/16'h0001 -> 16'h7FFF, ovf=1.
//    16'hF000/16'h0000 -> 16'h8000, ovf=1.
//    16'h0000/16'h0000 -> 16'h7FFF, ovf=1. Latency is still 28.
//  5 Pulse start during CALC (A/B changed) -> ignored; the first operation's result is unaffected.
//    Then a new start in DONE -> finish drops next cycle, and the new result arrives 28 edges later.
//  6 Assert rst=0 at cycle 10 of CALC -> outputs go to 0 asynchronously.
//    After release, a fresh op 16'h0400/16'h0400 -> 16'h0400, ovf=0.
//  100 random vectors checked against a reference model of trunc((A<<FRAC)/B) with saturation.

Source files
------------

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider (restoring radix-2, one quotient bit per clock).
// result = A / B in Q(WIDTH-FRAC_BITS-1).FRAC_BITS, truncated toward zero, saturating on overflow or B==0.
module fixed_point_divider #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             finish
);
  localparam int DW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0]    POS_MAX = DW'((2**(WIDTH-1)) - 1);
  localparam logic [DW-1:0]    NEG_MAX = DW'(2**(WIDTH-1));
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;

  logic             start_prev, accept;
  logic             s_a, s_b, bz, neg, ge;
  logic [WIDTH-1:0] mag_a, mag_b, rem;
  logic [WIDTH:0]   rem_sh, rem_nx;
  logic [DW-1:0]    dividend, quo;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] fix_res;
  logic             fix_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (accept) state_nx = CALC;
      CALC:       if (cnt == '0) state_nx = FIX;
      FIX:        state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept = start && !start_prev && (state == IDLE || state == DONE);
    mag_a  = A[WIDTH-1] ? -A : A;
    rem_sh = {rem, dividend[DW-1]};
    ge     = rem_sh >= {1'b0, mag_b};
    rem_nx = ge ? rem_sh - {1'b0, mag_b} : rem_sh;
  end

  // Remainder stays below |B| <= 2^(WIDTH-1), so WIDTH bits hold it between steps.
  always_comb begin
    neg     = s_a ^ s_b;
    fix_ovf = 1'b0;
    fix_res = '0;
    if (bz) begin
      fix_ovf = 1'b1;
      fix_res = s_a ? SAT_NEG : SAT_POS;
    end else if (!neg && quo > POS_MAX) begin
      fix_ovf = 1'b1;
      fix_res = SAT_POS;
    end else if (neg && quo > NEG_MAX) begin
      fix_ovf = 1'b1;
      fix_res = SAT_NEG;
    end else begin
      fix_res = neg ? -quo[WIDTH-1:0] : quo[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_prev    <= 1'b0;
      s_a           <= 1'b0;
      s_b           <= 1'b0;
      bz            <= 1'b0;
      mag_b         <= '0;
      rem           <= '0;
      dividend      <= '0;
      quo           <= '0;
      cnt           <= '0;
      result        <= '0;
      overflow_flag <= 1'b0;
      finish        <= 1'b0;
    end else begin
      start_prev <= start;
      if (accept) begin
        s_a      <= A[WIDTH-1];
        s_b      <= B[WIDTH-1];
        bz       <= (B == '0);
        mag_b    <= B[WIDTH-1] ? -B : B;
        dividend <= {mag_a, {FRAC_BITS{1'b0}}};
        rem      <= '0;
        quo      <= '0;
        cnt      <= CW'(DW - 1);
        finish   <= 1'b0;
      end else if (state == DONE) begin
        finish <= 1'b1;
      end
      if (state == CALC) begin
        dividend <= dividend << 1;
        quo      <= {quo[DW-2:0], ge};
        rem      <= rem_nx[WIDTH-1:0];
        cnt      <= cnt - 1'b1;
      end
      if (state == FIX) begin
        result        <= fix_res;
        overflow_flag <= fix_ovf;
      end
    end
  end
endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed + random bench for fixed_point_divider against an integer-arithmetic reference.
module tb_fixed_point_divider;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [15:0] result;
  logic        overflow_flag, finish;
  int          tests = 0, fails = 0;
  int          lat;

  fixed_point_divider #(.WIDTH(16), .FRAC_BITS(10)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .start(start),
    .result(result), .overflow_flag(overflow_flag), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // trunc((A << FRAC) / B) with saturation, computed on plain integers.
  function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    longint na, nb, q;
    logic [15:0] r;
    logic o;
    na = longint'($signed(a));
    nb = longint'($signed(b));
    if (nb == 0) begin
      o = 1'b1; r = a[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      q = (na * 1024) / nb;
      if (q > 32767)       begin o = 1'b1; r = 16'h7FFF; end
      else if (q < -32768) begin o = 1'b1; r = 16'h8000; end
      else                 begin o = 1'b0; r = q[15:0]; end
    end
    return {o, r};
  endfunction

  // Accept edge is edge 0; lat counts edges until finish is seen high.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        input int pulse_at, output int l);
    @(negedge clk); A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    chk("finish_low_after_accept", finish, 0);
    if (hold <= 1) start = 1'b0;
    l = 0;
    while (finish !== 1'b1 && l < 40) begin
      @(posedge clk); l++; #1;
      if (l >= hold - 1) start = 1'b0;
      if (pulse_at > 0 && l == pulse_at) begin
        A = 16'($urandom); B = 16'($urandom); start = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_r, input logic exp_o);
    int l;
    run_op(a, b, 1, 0, l);
    chk({tag, "_lat"}, l, 28);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_ovf"}, overflow_flag, exp_o);
  endtask

  initial begin
    logic [16:0] exp;
    logic [15:0] ra, rb;

    // 1: reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_ovf", overflow_flag, 0);
    chk("rst_finish", finish, 0);
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_finish", finish, 0);
    chk("idle_result", result, 0);

    // 2: held start -> one operation, finish held
    run_op(16'h0C00, 16'h0800, 4, 0, lat);
    chk("held_lat", lat, 28);
    chk("held_res", result, 16'h0600);
    chk("held_ovf", overflow_flag, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("held_finish_stays", finish, 1);
    chk("held_res_stays", result, 16'h0600);

    // 3: sign and truncation
    check_op("neg_a",   16'hF400, 16'h0800, 16'hFA00, 1'b0);
    check_op("third",   16'h0400, 16'h0C00, 16'h0155, 1'b0);
    check_op("mthird",  16'hFC00, 16'h0C00, 16'hFEAB, 1'b0);
    check_op("minval",  16'h8000, 16'h0400, 16'h8000, 1'b0);
    check_op("neg_b",   16'h0C00, 16'hF800, 16'hFA00, 1'b0);

    // 4: overflow and divide by zero
    check_op("ovf_pos", 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
    check_op("ovf_neg", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1);
    check_op("dz_neg",  16'hF000, 16'h0000, 16'h8000, 1'b1);
    check_op("dz_zero", 16'h0000, 16'h0000, 16'h7FFF, 1'b1);

    // 5: start pulse in CALC ignored, then restart from DONE
    run_op(16'h0C00, 16'h0800, 1, 6, lat);
    chk("ign_lat", lat, 28);
    chk("ign_res", result, 16'h0600);
    chk("ign_ovf", overflow_flag, 0);
    check_op("restart", 16'hF400, 16'h0C00, 16'hFC00, 1'b0);

    // 6: reset mid-CALC
    check_op("pre_rst", 16'h0C00, 16'h0800, 16'h0600, 1'b0);
    @(negedge clk); A = 16'h0400; B = 16'h0C00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midcalc_res_held", result, 16'h0600);
    chk("midcalc_finish", finish, 0);
    rst = 1'b0;
    #1;
    chk("async_rst_res", result, 0);
    chk("async_rst_ovf", overflow_flag, 0);
    chk("async_rst_finish", finish, 0);
    @(negedge clk); rst = 1'b1;
    check_op("post_rst", 16'h0400, 16'h0400, 16'h0400, 1'b0);

    // random vectors, divisor sometimes small or zero to reach saturation
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom_range(0, 15));
        1:       rb = -16'($urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      exp = ref_div(ra, rb);
      check_op($sformatf("rnd%0d", i), ra, rb, exp[15:0], exp[16]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
